fetch_mem_arbiter: RTL and testbench
====================================

Name: fetch_mem_arbiter

Overview:
Shares the single processor–memory port between the Fetch stage's instruction reads and the LSU's loads and stores. Tracks every outstanding load tag and which requester owns it. Routes tagged memory responses back to their owner. On a branch restore it squashes in-flight fetch reads, so stale instruction lines never reach the instruction buffer. Sits between Fetch/LSU and the memory bus, replacing any direct Fetch-to-memory connection.

Parameters:
ADDR_W, 32, address width (matches ADDR)
DATA_W, 64, memory data width
TAG_BITS, 4, memory transaction tag width; tag 0 means "not accepted" or "no response"
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch gets forced priority
MAX_FETCH_OUT, 4, maximum outstanding fetch reads

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
fetch_req  in  1  fetch read request; held until granted
fetch_addr  in  ADDR_W  fetch line address
fetch_gnt  out  1  fetch request accepted by memory this cycle
fetch_resp_valid  out  1  fetch read data valid
fetch_resp_data  out  DATA_W  fetch read data
fetch_full  out  1  outstanding fetch count == MAX_FETCH_OUT
lsu_req  in  1  LSU request; held until granted
lsu_is_store  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  LSU address
lsu_wdata  in  DATA_W  store data
lsu_gnt  out  1  LSU request accepted this cycle
lsu_resp_valid  out  1  LSU load data valid
lsu_resp_data  out  DATA_W  LSU load data
restore_valid  in  1  branch-stack restore (mispredict)
proc2mem_command  out  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
proc2mem_addr  out  ADDR_W  bus address
proc2mem_data  out  DATA_W  bus store data
mem2proc_transaction_tag  in  TAG_BITS  nonzero = request accepted, with this tag
mem2proc_data  in  DATA_W  response data
mem2proc_data_tag  in  TAG_BITS  nonzero = response for this tag
tag_collision  out  1  sticky error: accepted tag already valid in table

Behaviour:
- Reset (reset_n low, async):
  - All table entries invalid; starve_cnt=0; fetch_out_cnt=0.
  - Response registers cleared; tag_collision=0.
  - Outputs: proc2mem_command=BUS_NONE, all gnt/resp_valid=0.
  - Reset asserted mid-transaction discards all outstanding tags; responses arriving after reset deassertion are dropped, since their entries are invalid.
- Fetch eligibility: fetch_eligible = fetch_req & ~restore_valid & ~fetch_full.
- Arbitration (combinational, same cycle):
  - Only one requester eligible: that requester is selected.
  - Both eligible: fetch wins if starve_cnt==STARVE_LIMIT, else LSU wins.
  - Neither eligible: BUS_NONE, addr/data driven 0.
- Grant: selected requester's gnt = (mem2proc_transaction_tag != 0). Unselected gnt=0. No grant without a bus command.
- starve_cnt:
  - Saturating increment when fetch_eligible & ~fetch_gnt.
  - Cleared on fetch_gnt or when ~fetch_eligible.
- Tag table (2^TAG_BITS entries: valid, owner, squashed):
  - Allocation: an accepted load (fetch, or LSU with ~lsu_is_store) writes entry[tag] <= {1, owner, 0} at the clock edge.
  - Stores never allocate.
  - Allocating onto a valid entry sets tag_collision; the new allocation wins.
- fetch_out_cnt:
  - +1 on fetch_gnt; −1 when a fetch entry is freed.
  - Both in one cycle: net 0.
  - fetch_full = (fetch_out_cnt == MAX_FETCH_OUT).
- Response (mem2proc_data_tag != 0 and entry valid):
  - Entry freed at the edge.
  - Owner LSU: lsu_resp_valid/data registered, asserted the next cycle.
  - Owner fetch, not squashed and no restore_valid this cycle: fetch_resp_valid/data registered next cycle. Otherwise dropped.
  - Response to an invalid entry: ignored.
- Output gating: fetch_resp_valid = registered valid & ~restore_valid; a restore in the output cycle also suppresses the response.
- restore_valid: sets squashed on every valid fetch entry at the edge. LSU entries are untouched.
- Same-tag response and allocation in one cycle: free first, then allocate. The entry ends valid with the new owner.
- Response valid outputs are single-cycle pulses; there is no backpressure from consumers.

Optional Feature:
- Macro FETCH_MEM_ARB_PERF_EN.
- Defined: adds three 32-bit wrapping output counters, cleared on reset:
  - perf_fetch_grants (+1 per fetch_gnt)
  - perf_lsu_grants (+1 per lsu_gnt)
  - perf_squash_drops (+1 per dropped fetch response)
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Fetch only, fetch_addr=0x100, transaction_tag=3, data_tag=3 two cycles later with data 0xDEAD → fetch_gnt=1 in the request cycle; fetch_resp_valid=1 and data 0xDEAD one cycle after the response; fetch_out_cnt returns to 0.
- Both requesting continuously, transaction_tag always nonzero, STARVE_LIMIT=4 → LSU granted 4 cycles, fetch granted on cycle 5, LSU on cycle 6 (counter cleared).
- Fetch load tag 5 accepted; restore_valid pulsed before data_tag=5 arrives → no fetch_resp_valid; fetch_out_cnt decrements; LSU load tag 6 returning afterwards is still delivered.
- 4 fetch grants (tags 1–4) with no responses → fetch_full=1; 5th fetch_req gets no grant while LSU is granted; response tag 1 → fetch_full drops the next cycle.
- LSU store accepted with tag 7, then data_tag=7 → no allocation; no lsu_resp_valid.
- reset_n asserted low mid-cycle with 2 outstanding tags → outputs 0 immediately; a later data_tag matching an old tag produces no response.

Source files
------------

// File: rtl/fetch_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_mem_arbiter_if
// Description : Fetch, LSU and memory-bus signal bundle for fetch_mem_arbiter.
//               The master side is the fetch/LSU/memory environment; the
//               slave side is the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_mem_arbiter_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int TAG_BITS = 4
);
    logic                fetch_req;
    logic [ADDR_W-1:0]   fetch_addr;
    logic                fetch_gnt;
    logic                fetch_resp_valid;
    logic [DATA_W-1:0]   fetch_resp_data;
    logic                fetch_full;

    logic                lsu_req;
    logic                lsu_is_store;
    logic [ADDR_W-1:0]   lsu_addr;
    logic [DATA_W-1:0]   lsu_wdata;
    logic                lsu_gnt;
    logic                lsu_resp_valid;
    logic [DATA_W-1:0]   lsu_resp_data;

    logic [1:0]          proc2mem_command;
    logic [ADDR_W-1:0]   proc2mem_addr;
    logic [DATA_W-1:0]   proc2mem_data;
    logic [TAG_BITS-1:0] mem2proc_transaction_tag;
    logic [DATA_W-1:0]   mem2proc_data;
    logic [TAG_BITS-1:0] mem2proc_data_tag;

    modport master (
        output fetch_req, fetch_addr,
        output lsu_req, lsu_is_store, lsu_addr, lsu_wdata,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  fetch_gnt, fetch_resp_valid, fetch_resp_data, fetch_full,
        input  lsu_gnt, lsu_resp_valid, lsu_resp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  lsu_req, lsu_is_store, lsu_addr, lsu_wdata,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output fetch_gnt, fetch_resp_valid, fetch_resp_data, fetch_full,
        output lsu_gnt, lsu_resp_valid, lsu_resp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_mem_arbiter
// Description : Shares the memory port between fetch reads and LSU loads and
//               stores, tracks outstanding load tags, routes responses to
//               their owner and squashes fetch reads on branch restore.
//               Optional macro FETCH_MEM_ARB_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 64,
    parameter int TAG_BITS      = 4,
    parameter int STARVE_LIMIT  = 4,
    parameter int MAX_FETCH_OUT = 4
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    fetch_mem_arbiter_if.slave    bus,
    input  wire logic             restore_valid,
    output logic                  tag_collision
`ifdef FETCH_MEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_fetch_grants,
    output logic [31:0]           perf_lsu_grants,
    output logic [31:0]           perf_squash_drops
`endif
);

    localparam int c_NUM_TAGS = 1 << TAG_BITS;
    localparam int c_SC_W     = $clog2(STARVE_LIMIT + 1);
    localparam int c_FC_W     = $clog2(MAX_FETCH_OUT + 1);

    localparam logic [1:0] c_BUS_NONE  = 2'd0;
    localparam logic [1:0] c_BUS_LOAD  = 2'd1;
    localparam logic [1:0] c_BUS_STORE = 2'd2;

    localparam logic [c_SC_W-1:0] c_STARVE_LIMIT  = c_SC_W'(STARVE_LIMIT);
    localparam logic [c_FC_W-1:0] c_MAX_FETCH_OUT = c_FC_W'(MAX_FETCH_OUT);

    logic [c_SC_W-1:0]     r_starve_cnt;
    logic [c_FC_W-1:0]     r_fetch_out_cnt;
    logic [c_NUM_TAGS-1:0] r_valid;
    logic [c_NUM_TAGS-1:0] r_owner_fetch;
    logic [c_NUM_TAGS-1:0] r_squashed;
    logic                  r_fetch_resp_valid;
    logic [DATA_W-1:0]     r_fetch_resp_data;
    logic                  r_lsu_resp_valid;
    logic [DATA_W-1:0]     r_lsu_resp_data;
    logic                  r_tag_collision;

    logic                  w_fetch_full;
    logic                  w_fetch_elig;
    logic                  w_lsu_elig;
    logic                  w_sel_fetch;
    logic                  w_sel_lsu;
    logic                  w_accept;
    logic                  w_fetch_gnt;
    logic                  w_lsu_gnt;
    logic                  w_alloc;
    logic                  w_collide;
    logic [TAG_BITS-1:0]   w_ttag;
    logic [TAG_BITS-1:0]   w_dtag;
    logic                  w_resp_hit;
    logic                  w_resp_fetch;
    logic                  w_resp_lsu;
    logic                  w_fetch_deliver;
    logic                  w_fetch_drop;
    logic [c_NUM_TAGS-1:0] w_valid_nxt;
    logic [c_NUM_TAGS-1:0] w_owner_nxt;
    logic [c_NUM_TAGS-1:0] w_squash_nxt;

    // ------------------------------------------------------------------
    // Arbitration and bus drive
    // ------------------------------------------------------------------
    assign w_ttag       = bus.mem2proc_transaction_tag;
    assign w_dtag       = bus.mem2proc_data_tag;
    assign w_fetch_full = (r_fetch_out_cnt == c_MAX_FETCH_OUT);
    // Requests are masked while reset is held so the bus is quiet immediately.
    assign w_fetch_elig = reset_n & bus.fetch_req & ~restore_valid & ~w_fetch_full;
    assign w_lsu_elig   = reset_n & bus.lsu_req;
    assign w_sel_fetch  = w_fetch_elig & (~w_lsu_elig | (r_starve_cnt == c_STARVE_LIMIT));
    assign w_sel_lsu    = w_lsu_elig & ~w_sel_fetch;
    assign w_accept     = |w_ttag;
    assign w_fetch_gnt  = w_sel_fetch & w_accept;
    assign w_lsu_gnt    = w_sel_lsu & w_accept;

    always_comb begin
        bus.proc2mem_command = c_BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (w_sel_fetch) begin
            bus.proc2mem_command = c_BUS_LOAD;
            bus.proc2mem_addr    = bus.fetch_addr;
        end else if (w_sel_lsu) begin
            bus.proc2mem_command = bus.lsu_is_store ? c_BUS_STORE : c_BUS_LOAD;
            bus.proc2mem_addr    = bus.lsu_addr;
            bus.proc2mem_data    = bus.lsu_is_store ? bus.lsu_wdata : '0;
        end
    end

    // ------------------------------------------------------------------
    // Tag table: free on response, then allocate on accepted load
    // ------------------------------------------------------------------
    assign w_alloc         = w_fetch_gnt | (w_lsu_gnt & ~bus.lsu_is_store);
    assign w_resp_hit      = (|w_dtag) & r_valid[w_dtag];
    assign w_resp_fetch    = w_resp_hit & r_owner_fetch[w_dtag];
    assign w_resp_lsu      = w_resp_hit & ~r_owner_fetch[w_dtag];
    assign w_fetch_deliver = w_resp_fetch & ~r_squashed[w_dtag] & ~restore_valid;
    assign w_fetch_drop    = w_resp_fetch & ~w_fetch_deliver;
    // A same-tag response in this cycle frees the entry before reuse.
    assign w_collide       = w_alloc & r_valid[w_ttag] & ~(w_resp_hit & (w_dtag == w_ttag));

    always_comb begin
        w_valid_nxt  = r_valid;
        w_owner_nxt  = r_owner_fetch;
        w_squash_nxt = r_squashed;
        if (restore_valid) begin
            w_squash_nxt = r_squashed | (r_valid & r_owner_fetch);
        end
        if (w_resp_hit) begin
            w_valid_nxt[w_dtag] = 1'b0;
        end
        if (w_alloc) begin
            w_valid_nxt[w_ttag]  = 1'b1;
            w_owner_nxt[w_ttag]  = w_fetch_gnt;
            w_squash_nxt[w_ttag] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid            <= '0;
            r_owner_fetch      <= '0;
            r_squashed         <= '0;
            r_starve_cnt       <= '0;
            r_fetch_out_cnt    <= '0;
            r_fetch_resp_valid <= 1'b0;
            r_fetch_resp_data  <= '0;
            r_lsu_resp_valid   <= 1'b0;
            r_lsu_resp_data    <= '0;
            r_tag_collision    <= 1'b0;
        end else begin
            r_valid       <= w_valid_nxt;
            r_owner_fetch <= w_owner_nxt;
            r_squashed    <= w_squash_nxt;

            if (w_fetch_elig & ~w_fetch_gnt) begin
                if (r_starve_cnt != c_STARVE_LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + c_SC_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end

            if (w_fetch_gnt & ~w_resp_fetch) begin
                r_fetch_out_cnt <= r_fetch_out_cnt + c_FC_W'(1);
            end else if (~w_fetch_gnt & w_resp_fetch) begin
                r_fetch_out_cnt <= r_fetch_out_cnt - c_FC_W'(1);
            end

            r_fetch_resp_valid <= w_fetch_deliver;
            r_lsu_resp_valid   <= w_resp_lsu;
            if (w_fetch_deliver) begin
                r_fetch_resp_data <= bus.mem2proc_data;
            end
            if (w_resp_lsu) begin
                r_lsu_resp_data <= bus.mem2proc_data;
            end

            if (w_collide) begin
                r_tag_collision <= 1'b1;
            end
        end
    end

    assign bus.fetch_gnt        = w_fetch_gnt;
    assign bus.lsu_gnt          = w_lsu_gnt;
    assign bus.fetch_full       = w_fetch_full;
    // A restore in the delivery cycle still kills the stale line.
    assign bus.fetch_resp_valid = r_fetch_resp_valid & ~restore_valid;
    assign bus.fetch_resp_data  = r_fetch_resp_data;
    assign bus.lsu_resp_valid   = r_lsu_resp_valid;
    assign bus.lsu_resp_data    = r_lsu_resp_data;
    assign tag_collision        = r_tag_collision;

`ifdef FETCH_MEM_ARB_PERF_EN
    logic [31:0] w_drop_inc;

    assign w_drop_inc = 32'(w_fetch_drop) + 32'(r_fetch_resp_valid & restore_valid);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_grants <= '0;
            perf_lsu_grants   <= '0;
            perf_squash_drops <= '0;
        end else begin
            perf_fetch_grants <= perf_fetch_grants + 32'(w_fetch_gnt);
            perf_lsu_grants   <= perf_lsu_grants + 32'(w_lsu_gnt);
            perf_squash_drops <= perf_squash_drops + w_drop_inc;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_mem_arbiter
// Description : Self-checking bench for fetch_mem_arbiter: vector table plus
//               directed restore, store, collision and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_mem_arbiter;

    localparam logic [31:0] c_FADDR = 32'h100;
    localparam logic [31:0] c_LADDR = 32'h200;
    localparam logic [63:0] c_WDATA = 64'h5A5A;

    logic clock;
    logic reset_n;
    logic restore_valid;
    logic tag_collision;
    int   n_err;
    int   n_chk;

    fetch_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64), .TAG_BITS(4)) bus_if ();

    fetch_mem_arbiter #(
        .ADDR_W(32), .DATA_W(64), .TAG_BITS(4), .STARVE_LIMIT(4), .MAX_FETCH_OUT(4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bus_if.slave),
        .restore_valid (restore_valid),
        .tag_collision (tag_collision)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        fr, lr, st, rs;
        logic [3:0]  tt, dt;
        logic [63:0] md;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic        fg, lg, frv, lrv, full;
        logic [63:0] rd;
        int          cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic fr, logic lr, logic st, logic rs,
                                logic [3:0] tt, logic [3:0] dt, logic [63:0] md,
                                logic [1:0] cmd, logic [31:0] addr, logic fg, logic lg,
                                logic frv, logic lrv, logic full, logic [63:0] rd, int cnt);
        vec_t v;
        v.fr = fr; v.lr = lr; v.st = st; v.rs = rs; v.tt = tt; v.dt = dt; v.md = md;
        v.cmd = cmd; v.addr = addr; v.fg = fg; v.lg = lg; v.frv = frv; v.lrv = lrv;
        v.full = full; v.rd = rd; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic fr, input logic lr, input logic st, input logic rs,
                          input logic [3:0] tt, input logic [3:0] dt, input logic [63:0] md);
        bus_if.fetch_req                = fr;
        bus_if.lsu_req                  = lr;
        bus_if.lsu_is_store             = st;
        restore_valid                   = rs;
        bus_if.mem2proc_transaction_tag = tt;
        bus_if.mem2proc_data_tag        = dt;
        bus_if.mem2proc_data            = md;
    endtask

    task automatic step(input logic fr, input logic lr, input logic st, input logic rs,
                        input logic [3:0] tt, input logic [3:0] dt, input logic [63:0] md);
        @(posedge clock);
        #1;
        set_in(fr, lr, st, rs, tt, dt, md);
        @(negedge clock);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_err = 0;
        n_chk = 0;
        reset_n = 1'b0;
        bus_if.fetch_addr = c_FADDR;
        bus_if.lsu_addr   = c_LADDR;
        bus_if.lsu_wdata  = c_WDATA;
        set_in(0, 0, 0, 0, 0, 0, 64'h0);

        // Fetch single read, tag 3
        vt.push_back(mk(1,0,0,0,3,0,0,             1,c_FADDR,1,0,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0,1));
        vt.push_back(mk(0,0,0,0,0,3,64'hDEAD,      0,0,0,0,0,0,0,0,1));
        vt.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,0,0,64'hDEAD,0));
        // Starvation: LSU x4, fetch on 5th, LSU on 6th
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(1,1,1,0,9,0,0,         2,c_LADDR,0,1,0,0,0,0,0));
        vt.push_back(mk(1,1,1,0,9,0,0,             1,c_FADDR,1,0,0,0,0,0,0));
        vt.push_back(mk(1,1,1,0,9,0,0,             2,c_LADDR,0,1,0,0,0,0,1));
        vt.push_back(mk(0,0,0,0,0,9,64'h99,        0,0,0,0,0,0,0,0,1));
        vt.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,0,0,64'h99,0));
        // LSU load, tag 8
        vt.push_back(mk(0,1,0,0,8,0,0,             1,c_LADDR,0,1,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,8,64'h88,        0,0,0,0,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,0,1,0,64'h88,0));
        // Fill fetch window with tags 1..4
        vt.push_back(mk(1,0,0,0,1,0,0,             1,c_FADDR,1,0,0,0,0,0,0));
        vt.push_back(mk(1,0,0,0,2,0,0,             1,c_FADDR,1,0,0,0,0,0,1));
        vt.push_back(mk(1,0,0,0,3,0,0,             1,c_FADDR,1,0,0,0,0,0,2));
        vt.push_back(mk(1,0,0,0,4,0,0,             1,c_FADDR,1,0,0,0,0,0,3));
        vt.push_back(mk(1,1,1,0,5,0,0,             2,c_LADDR,0,1,0,0,1,0,4));
        vt.push_back(mk(1,0,0,0,0,1,64'h11,        0,0,0,0,0,0,1,0,4));
        vt.push_back(mk(1,0,0,0,6,0,0,             1,c_FADDR,1,0,1,0,0,64'h11,3));
        vt.push_back(mk(0,0,0,0,0,2,64'h22,        0,0,0,0,0,0,1,0,4));
        vt.push_back(mk(0,0,0,0,0,3,64'h33,        0,0,0,0,1,0,0,64'h22,3));
        vt.push_back(mk(0,0,0,0,0,4,64'h44,        0,0,0,0,1,0,0,64'h33,2));
        vt.push_back(mk(0,0,0,0,0,6,64'h66,        0,0,0,0,1,0,0,64'h44,1));
        vt.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,0,0,64'h66,0));

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cmd", 64'(bus_if.proc2mem_command), 64'd0);
        chk("rst_fgnt", 64'(bus_if.fetch_gnt), 64'd0);
        chk("rst_frv", 64'(bus_if.fetch_resp_valid), 64'd0);
        chk("rst_lrv", 64'(bus_if.lsu_resp_valid), 64'd0);
        chk("rst_full", 64'(bus_if.fetch_full), 64'd0);
        chk("rst_coll", 64'(tag_collision), 64'd0);
        reset_n = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].fr, vt[i].lr, vt[i].st, vt[i].rs, vt[i].tt, vt[i].dt, vt[i].md);
            chk($sformatf("v%0d_cmd", i), 64'(bus_if.proc2mem_command), 64'(vt[i].cmd));
            chk($sformatf("v%0d_addr", i), 64'(bus_if.proc2mem_addr), 64'(vt[i].addr));
            chk($sformatf("v%0d_fgnt", i), 64'(bus_if.fetch_gnt), 64'(vt[i].fg));
            chk($sformatf("v%0d_lgnt", i), 64'(bus_if.lsu_gnt), 64'(vt[i].lg));
            chk($sformatf("v%0d_frv", i), 64'(bus_if.fetch_resp_valid), 64'(vt[i].frv));
            chk($sformatf("v%0d_lrv", i), 64'(bus_if.lsu_resp_valid), 64'(vt[i].lrv));
            chk($sformatf("v%0d_full", i), 64'(bus_if.fetch_full), 64'(vt[i].full));
            chk($sformatf("v%0d_fcnt", i), 64'(dut.r_fetch_out_cnt), 64'(vt[i].cnt));
            if (vt[i].frv)
                chk($sformatf("v%0d_fdata", i), bus_if.fetch_resp_data, vt[i].rd);
            if (vt[i].lrv)
                chk($sformatf("v%0d_ldata", i), bus_if.lsu_resp_data, vt[i].rd);
        end

        // Restore squashes in-flight fetch, LSU load unaffected
        step(1, 0, 0, 0, 5, 0, 64'h0);
        chk("rs_fgnt5", 64'(bus_if.fetch_gnt), 64'd1);
        step(0, 1, 0, 0, 6, 0, 64'h0);
        chk("rs_lgnt6", 64'(bus_if.lsu_gnt), 64'd1);
        step(1, 0, 0, 1, 7, 0, 64'h0);
        chk("rs_block_gnt", 64'(bus_if.fetch_gnt), 64'd0);
        chk("rs_block_cmd", 64'(bus_if.proc2mem_command), 64'd0);
        step(0, 0, 0, 0, 0, 5, 64'h55);
        chk("rs_cnt_before", 64'(dut.r_fetch_out_cnt), 64'd1);
        idle();
        chk("rs_no_frv", 64'(bus_if.fetch_resp_valid), 64'd0);
        chk("rs_cnt_after", 64'(dut.r_fetch_out_cnt), 64'd0);
        step(0, 0, 0, 0, 0, 6, 64'h66);
        idle();
        chk("rs_lrv6", 64'(bus_if.lsu_resp_valid), 64'd1);
        chk("rs_ldata6", bus_if.lsu_resp_data, 64'h66);

        // Restore in the delivery cycle suppresses the response
        step(1, 0, 0, 0, 2, 0, 64'h0);
        step(0, 0, 0, 0, 0, 2, 64'h22);
        step(0, 0, 0, 1, 0, 0, 64'h0);
        chk("rs_out_gate", 64'(bus_if.fetch_resp_valid), 64'd0);
        idle();
        chk("rs_out_pulse", 64'(bus_if.fetch_resp_valid), 64'd0);

        // Store never allocates
        step(0, 1, 1, 0, 7, 0, 64'h0);
        chk("st_gnt", 64'(bus_if.lsu_gnt), 64'd1);
        chk("st_cmd", 64'(bus_if.proc2mem_command), 64'd2);
        chk("st_wdata", bus_if.proc2mem_data, c_WDATA);
        step(0, 0, 0, 0, 0, 7, 64'h77);
        chk("st_noalloc", 64'(dut.r_valid), 64'd0);
        idle();
        chk("st_no_lrv", 64'(bus_if.lsu_resp_valid), 64'd0);
        chk("st_no_frv", 64'(bus_if.fetch_resp_valid), 64'd0);

        // Same-tag free and allocate: no collision, entry re-owned
        step(0, 1, 0, 0, 11, 0, 64'h0);
        step(0, 1, 0, 0, 11, 11, 64'hB1);
        idle();
        chk("same_tag_coll", 64'(tag_collision), 64'd0);
        chk("same_tag_valid", 64'(dut.r_valid), 64'h800);
        chk("same_tag_lrv", 64'(bus_if.lsu_resp_valid), 64'd1);
        step(0, 0, 0, 0, 0, 11, 64'hB2);
        idle();
        chk("same_tag_lrv2", 64'(bus_if.lsu_resp_valid), 64'd1);
        chk("same_tag_ldata2", bus_if.lsu_resp_data, 64'hB2);

        // Allocating onto a live tag is sticky-flagged
        step(0, 1, 0, 0, 10, 0, 64'h0);
        step(0, 1, 0, 0, 10, 0, 64'h0);
        idle();
        chk("coll_set", 64'(tag_collision), 64'd1);
        idle();
        chk("coll_sticky", 64'(tag_collision), 64'd1);

        // Asynchronous reset with outstanding tags
        step(1, 0, 0, 0, 1, 0, 64'h0);
        step(0, 1, 0, 0, 2, 0, 64'h0);
        step(1, 1, 0, 0, 0, 1, 64'h11);
        @(posedge clock);
        #1;
        set_in(1, 1, 0, 0, 3, 0, 64'h0);
        chk("ar_pre_frv", 64'(bus_if.fetch_resp_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_frv", 64'(bus_if.fetch_resp_valid), 64'd0);
        chk("ar_cmd", 64'(bus_if.proc2mem_command), 64'd0);
        chk("ar_fgnt", 64'(bus_if.fetch_gnt), 64'd0);
        chk("ar_lgnt", 64'(bus_if.lsu_gnt), 64'd0);
        chk("ar_coll", 64'(tag_collision), 64'd0);
        chk("ar_valid", 64'(dut.r_valid), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 2, 64'h22);
        idle();
        chk("ar_stale_lrv", 64'(bus_if.lsu_resp_valid), 64'd0);
        chk("ar_stale_frv", 64'(bus_if.fetch_resp_valid), 64'd0);
        chk("ar_cnt", 64'(dut.r_fetch_out_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
